// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the nibble counter; a single nibble still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_fourbit.sv
// Combinational 4-bit ripple-carry adder cell used as the nibble datapath.
module FourBit_Adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    always_comb begin : ripple
        logic [4:0] c;
        c     = '0;
        sum_o = '0;
        c[0]  = cin_i;
        for (int i = 0; i < 4; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that streams operands one nibble per clock through a single 4-bit cell.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NIBBLES*NIBBLE_W-1:0] a_in,
    input  logic [NIBBLES*NIBBLE_W-1:0] b_in,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLES*NIBBLE_W-1:0] sum_out,
    output logic                        cout_out
);

    localparam int unsigned W     = NIBBLES * NIBBLE_W;
    localparam int unsigned CNT_W = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [W-1:0]        a_q, b_q, res_q, sum_q;
    logic                carry_q, cout_q, busy_q, done_q;

    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic [W-1:0]        res_next;

    FourBit_Adder u_cell (
        .a_i    (a_q[NIBBLE_W-1:0]),
        .b_i    (b_q[NIBBLE_W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (nib_sum),
        .cout_o (nib_cout)
    );

    // Result fills from the top so nibble 0 ends up in the low bits after NIBBLES shifts.
    assign res_next = {nib_sum, res_q[W-1:NIBBLE_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    a_q     <= a_q >> NIBBLE_W;
                    b_q     <= b_q >> NIBBLE_W;
                    res_q   <= res_next;
                    carry_q <= nib_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        sum_q   <= res_next;
                        cout_q  <= nib_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum_out  = sum_q;
    assign cout_out = cout_q;

endmodule
